// File: rtl/eh2_lsu_amo_wrbuf.sv
// Two-entry write-back buffer for atomic results.
// Entries drain to the DCCM in capture order, one per granted cycle.
module eh2_lsu_amo_wrbuf #(
    parameter int unsigned DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_l,
    input  logic        amo_wr_valid_dc3,
    input  logic        flush_dc3,
    input  logic [31:0] amo_addr_dc3,
    input  logic [31:0] amo_data_dc3,
    input  logic        amo_tid_dc3,
    input  logic        dccm_wr_gnt,
    input  logic        ld_valid_dc1,
    input  logic [31:0] ld_addr_dc1,
    output logic        amowb_wren,
    output logic [31:0] amowb_addr,
    output logic [31:0] amowb_data,
    output logic        amowb_tid,
    output logic        amowb_full,
    output logic        amowb_empty,
    output logic        amowb_ld_hazard_dc1
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } wb_state_e;

    wb_state_e   state, state_nxt;
    logic        wr_ptr, rd_ptr;
    logic [31:0] addr_q [DEPTH];
    logic [31:0] data_q [DEPTH];
    logic        tid_q  [DEPTH];
    logic [DEPTH-1:0] valid_q;

    logic capture, retire, accept;

    assign capture = amo_wr_valid_dc3 & ~flush_dc3;
    assign retire  = amowb_wren & dccm_wr_gnt;
    // When full, a capture is only taken if the head frees its slot this cycle.
    assign accept  = capture & ((state != FULL) | retire);

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            state <= EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            EMPTY: if (accept) state_nxt = ONE;
            ONE: begin
                if (accept && !retire)      state_nxt = FULL;
                else if (!accept && retire) state_nxt = EMPTY;
            end
            FULL:  if (retire && !accept) state_nxt = ONE;
            default: state_nxt = EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            wr_ptr  <= 1'b0;
            rd_ptr  <= 1'b0;
            valid_q <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                addr_q[i] <= '0;
                data_q[i] <= '0;
                tid_q[i]  <= 1'b0;
            end
        end else begin
            // Clear before set: when full, the retiring slot is the one refilled.
            if (retire) begin
                valid_q[rd_ptr] <= 1'b0;
                rd_ptr          <= ~rd_ptr;
            end
            if (accept) begin
                valid_q[wr_ptr] <= 1'b1;
                addr_q[wr_ptr]  <= amo_addr_dc3;
                data_q[wr_ptr]  <= amo_data_dc3;
                tid_q[wr_ptr]   <= amo_tid_dc3;
                wr_ptr          <= ~wr_ptr;
            end
        end
    end

    assign amowb_wren  = (state != EMPTY);
    assign amowb_full  = (state == FULL);
    assign amowb_empty = (state == EMPTY);
    assign amowb_addr  = addr_q[rd_ptr];
    assign amowb_data  = data_q[rd_ptr];
    assign amowb_tid   = tid_q[rd_ptr];

    always_comb begin
        amowb_ld_hazard_dc1 = capture & (amo_addr_dc3[31:2] == ld_addr_dc1[31:2]);
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (valid_q[i] && (addr_q[i][31:2] == ld_addr_dc1[31:2]))
                amowb_ld_hazard_dc1 = 1'b1;
        end
        amowb_ld_hazard_dc1 = amowb_ld_hazard_dc1 & ld_valid_dc1;
    end

endmodule

// File: tb/tb_eh2_lsu_amo_wrbuf.sv
// Directed bench for the atomic write-back buffer.
// Inputs change 1 time unit after each rising edge; outputs are checked there too.
module tb_eh2_lsu_amo_wrbuf;

    logic        clk;
    logic        rst_l;
    logic        amo_wr_valid_dc3;
    logic        flush_dc3;
    logic [31:0] amo_addr_dc3;
    logic [31:0] amo_data_dc3;
    logic        amo_tid_dc3;
    logic        dccm_wr_gnt;
    logic        ld_valid_dc1;
    logic [31:0] ld_addr_dc1;
    logic        amowb_wren;
    logic [31:0] amowb_addr;
    logic [31:0] amowb_data;
    logic        amowb_tid;
    logic        amowb_full;
    logic        amowb_empty;
    logic        amowb_ld_hazard_dc1;

    int unsigned total = 0;
    int unsigned bad   = 0;

    eh2_lsu_amo_wrbuf #(.DEPTH(2)) dut (
        .clk                 (clk),
        .rst_l               (rst_l),
        .amo_wr_valid_dc3    (amo_wr_valid_dc3),
        .flush_dc3           (flush_dc3),
        .amo_addr_dc3        (amo_addr_dc3),
        .amo_data_dc3        (amo_data_dc3),
        .amo_tid_dc3         (amo_tid_dc3),
        .dccm_wr_gnt         (dccm_wr_gnt),
        .ld_valid_dc1        (ld_valid_dc1),
        .ld_addr_dc1         (ld_addr_dc1),
        .amowb_wren          (amowb_wren),
        .amowb_addr          (amowb_addr),
        .amowb_data          (amowb_data),
        .amowb_tid           (amowb_tid),
        .amowb_full          (amowb_full),
        .amowb_empty         (amowb_empty),
        .amowb_ld_hazard_dc1 (amowb_ld_hazard_dc1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Capturing into a full buffer without a same-cycle grant is a protocol violation.
    a_no_capture_when_full: assert property (@(posedge clk) disable iff (!rst_l)
        !(amo_wr_valid_dc3 && !flush_dc3 && amowb_full && !dccm_wr_gnt))
        else $error("capture while full without grant");

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cap(input logic [31:0] a, input logic [31:0] d, input logic t);
        amo_wr_valid_dc3 = 1'b1;
        amo_addr_dc3     = a;
        amo_data_dc3     = d;
        amo_tid_dc3      = t;
    endtask

    initial begin
        rst_l            = 1'b0;
        amo_wr_valid_dc3 = 1'b0;
        flush_dc3        = 1'b0;
        amo_addr_dc3     = '0;
        amo_data_dc3     = '0;
        amo_tid_dc3      = 1'b0;
        dccm_wr_gnt      = 1'b0;
        ld_valid_dc1     = 1'b0;
        ld_addr_dc1      = '0;
        #3;
        chk("rst_wren",  32'(amowb_wren),  32'd0);
        chk("rst_empty", 32'(amowb_empty), 32'd1);
        chk("rst_full",  32'(amowb_full),  32'd0);
        chk("rst_addr",  amowb_addr,       32'd0);
        chk("rst_data",  amowb_data,       32'd0);
        chk("rst_tid",   32'(amowb_tid),   32'd0);
        chk("rst_haz",   32'(amowb_ld_hazard_dc1), 32'd0);
        tick();
        rst_l = 1'b1;
        tick();

        // Single capture with grant held high
        dccm_wr_gnt = 1'b1;
        cap(32'h0000_F004, 32'hDEAD_BEEF, 1'b1);
        tick();
        amo_wr_valid_dc3 = 1'b0;
        chk("single_wren", 32'(amowb_wren), 32'd1);
        chk("single_addr", amowb_addr, 32'h0000_F004);
        chk("single_data", amowb_data, 32'hDEAD_BEEF);
        chk("single_tid",  32'(amowb_tid), 32'd1);
        tick();
        chk("single_wren_off", 32'(amowb_wren),  32'd0);
        chk("single_empty",    32'(amowb_empty), 32'd1);

        // Back-pressure: fill without grant, then drain in order
        dccm_wr_gnt = 1'b0;
        cap(32'h100, 32'h11, 1'b0);
        tick();
        cap(32'h104, 32'h22, 1'b0);
        tick();
        amo_wr_valid_dc3 = 1'b0;
        chk("bp_full",  32'(amowb_full), 32'd1);
        chk("bp_addr0", amowb_addr, 32'h100);
        chk("bp_data0", amowb_data, 32'h11);
        tick();
        chk("bp_hold_addr", amowb_addr, 32'h100);
        chk("bp_hold_full", 32'(amowb_full), 32'd1);
        dccm_wr_gnt = 1'b1;
        tick();
        chk("bp_addr1", amowb_addr, 32'h104);
        chk("bp_data1", amowb_data, 32'h22);
        chk("bp_notfull", 32'(amowb_full), 32'd0);
        chk("bp_wren1", 32'(amowb_wren), 32'd1);
        tick();
        chk("bp_empty", 32'(amowb_empty), 32'd1);

        // Simultaneous capture and grant at count 1, across pointer wraps
        dccm_wr_gnt = 1'b0;
        cap(32'h200, 32'h1, 1'b0);
        tick();
        chk("sim_head0", amowb_addr, 32'h200);
        dccm_wr_gnt = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cap(32'h300 + 32'(4 * i), 32'h2 + 32'(i), 1'(i));
            tick();
            chk("sim_addr", amowb_addr, 32'h300 + 32'(4 * i));
            chk("sim_data", amowb_data, 32'h2 + 32'(i));
            chk("sim_tid",  32'(amowb_tid), 32'(i % 2));
            chk("sim_one",  32'({amowb_full, amowb_empty}), 32'd0);
        end
        amo_wr_valid_dc3 = 1'b0;
        tick();
        chk("sim_empty", 32'(amowb_empty), 32'd1);

        // Flush and load hazard
        dccm_wr_gnt = 1'b0;
        cap(32'h400, 32'h44, 1'b0);
        flush_dc3 = 1'b1;
        ld_valid_dc1 = 1'b1;
        ld_addr_dc1  = 32'h400;
        #1;
        chk("flush_no_haz", 32'(amowb_ld_hazard_dc1), 32'd0);
        tick();
        flush_dc3 = 1'b0;
        chk("flush_empty", 32'(amowb_empty), 32'd1);
        tick();
        amo_wr_valid_dc3 = 1'b0;
        ld_addr_dc1 = 32'h402;
        #1;
        chk("haz_match", 32'(amowb_ld_hazard_dc1), 32'd1);
        ld_addr_dc1 = 32'h408;
        #1;
        chk("haz_nomatch", 32'(amowb_ld_hazard_dc1), 32'd0);
        cap(32'h40B, 32'h55, 1'b0);
        dccm_wr_gnt = 1'b1;
        #1;
        chk("haz_dc3", 32'(amowb_ld_hazard_dc1), 32'd1);
        amo_wr_valid_dc3 = 1'b0;
        ld_valid_dc1 = 1'b0;
        #1;
        chk("haz_noload", 32'(amowb_ld_hazard_dc1), 32'd0);
        tick();
        chk("haz_drained", 32'(amowb_empty), 32'd1);

        // Reset in the middle of draining
        dccm_wr_gnt = 1'b0;
        cap(32'h600, 32'h66, 1'b1);
        tick();
        cap(32'h604, 32'h67, 1'b0);
        tick();
        amo_wr_valid_dc3 = 1'b0;
        dccm_wr_gnt = 1'b1;
        chk("rstmid_full", 32'(amowb_full), 32'd1);
        #2;
        rst_l = 1'b0;
        #1;
        chk("rstmid_wren",  32'(amowb_wren),  32'd0);
        chk("rstmid_empty", 32'(amowb_empty), 32'd1);
        chk("rstmid_addr",  amowb_addr,       32'd0);
        #1;
        rst_l = 1'b1;
        dccm_wr_gnt = 1'b0;
        tick();
        chk("rstmid_still_empty", 32'(amowb_empty), 32'd1);
        cap(32'h500, 32'h77, 1'b0);
        tick();
        amo_wr_valid_dc3 = 1'b0;
        chk("post_rst_wren", 32'(amowb_wren), 32'd1);
        chk("post_rst_addr", amowb_addr, 32'h500);
        chk("post_rst_data", amowb_data, 32'h77);
        dccm_wr_gnt = 1'b1;
        tick();
        chk("post_rst_empty", 32'(amowb_empty), 32'd1);
        dccm_wr_gnt = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
